// File: rtl/mem_arbiter.sv
// Three-way arbiter sharing one memory port between instruction read, data read and data write.
// Fixed priority DW > DR > I, with I promoted after any data access so it never waits behind two.
//
// state  | meaning
// IDLE   | no transfer; arbitrate pending requests
// GNT_I  | instruction read owns the memory port
// GNT_DR | data read owns the memory port
// GNT_DW | data write owns the memory port
module mem_arbiter #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              instr_re,
    input  logic [XLEN/8-1:0] instr_sel,
    input  logic [XLEN-1:0]   instr_addr,
    output logic              instr_ack,
    output logic [31:0]       instr_data,

    input  logic              dr_re,
    input  logic [XLEN/8-1:0] dr_sel,
    input  logic [XLEN-1:0]   dr_addr,
    output logic              dr_ack,
    output logic [XLEN-1:0]   dr_data,

    input  logic              dw_we,
    input  logic [XLEN/8-1:0] dw_sel,
    input  logic [XLEN-1:0]   dw_addr,
    input  logic [XLEN-1:0]   dw_data,
    output logic              dw_ack,

    output logic              mem_re,
    output logic              mem_we,
    output logic [XLEN/8-1:0] mem_sel,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_I  = 2'd1,
        GNT_DR = 2'd2,
        GNT_DW = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last_data <= 1'b0;
            mem_sel   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state <= state_nxt;
            // Request fields are captured once at grant; the requester holds them anyway.
            if (state == IDLE) begin
                case (state_nxt)
                    GNT_I: begin
                        last_data <= 1'b0;
                        mem_sel   <= instr_sel;
                        mem_addr  <= instr_addr;
                    end
                    GNT_DR: begin
                        last_data <= 1'b1;
                        mem_sel   <= dr_sel;
                        mem_addr  <= dr_addr;
                    end
                    GNT_DW: begin
                        last_data <= 1'b1;
                        mem_sel   <= dw_sel;
                        mem_addr  <= dw_addr;
                        mem_wdata <= dw_data;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_nxt = state;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        instr_ack = 1'b0;
        dr_ack    = 1'b0;
        dw_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (last_data && instr_re) state_nxt = GNT_I;
                else if (dw_we)            state_nxt = GNT_DW;
                else if (dr_re)            state_nxt = GNT_DR;
                else if (instr_re)         state_nxt = GNT_I;
            end
            GNT_I: begin
                mem_re    = 1'b1;
                instr_ack = mem_ack;
                if (mem_ack) state_nxt = IDLE;
            end
            GNT_DR: begin
                mem_re = 1'b1;
                dr_ack = mem_ack;
                if (mem_ack) state_nxt = IDLE;
            end
            GNT_DW: begin
                mem_we = 1'b1;
                dw_ack = mem_ack;
                if (mem_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign instr_data = mem_rdata[31:0];
    assign dr_data    = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mem_arbiter;
    localparam int XLEN = 32;
    localparam int SW   = XLEN / 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            instr_re, dr_re, dw_we;
    logic [SW-1:0]   instr_sel, dr_sel, dw_sel;
    logic [XLEN-1:0] instr_addr, dr_addr, dw_addr, dw_data;
    logic            instr_ack, dr_ack, dw_ack;
    logic [31:0]     instr_data;
    logic [XLEN-1:0] dr_data;
    logic            mem_re, mem_we, mem_ack;
    logic [SW-1:0]   mem_sel;
    logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .instr_re(instr_re), .instr_sel(instr_sel), .instr_addr(instr_addr),
        .instr_ack(instr_ack), .instr_data(instr_data),
        .dr_re(dr_re), .dr_sel(dr_sel), .dr_addr(dr_addr),
        .dr_ack(dr_ack), .dr_data(dr_data),
        .dw_we(dw_we), .dw_sel(dw_sel), .dw_addr(dw_addr), .dw_data(dw_data),
        .dw_ack(dw_ack),
        .mem_re(mem_re), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; outputs are checked 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        instr_re = 0; instr_sel = '0; instr_addr = '0;
        dr_re = 0; dr_sel = '0; dr_addr = '0;
        dw_we = 0; dw_sel = '0; dw_addr = '0; dw_data = '0;
        mem_ack = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic chk_acks(input string tag, input logic [2:0] exp);
        chk(tag, {instr_ack, dr_ack, dw_ack}, exp);
    endtask

    // random-phase model: one outstanding grant at a time, fields latched at grant
    int              owner;
    int              data_since_i;
    logic [XLEN-1:0] m_addr, m_wdata;
    logic [SW-1:0]   m_sel;
    bit              on[3];
    bit              seen[3];
    logic [XLEN-1:0] ra[3], rd[3];
    logic [SW-1:0]   rs[3];

    logic [XLEN-1:0] exp_addr[4];
    logic [2:0]      exp_ack[4];

    initial begin
        reset = 1;
        clear_inputs();

        // Reset state with a stray mem_ack present.
        mem_ack = 1;
        tick();
        #1;
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_sel", mem_sel, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk_acks("rst_acks", 3'b000);

        // Single instruction fetch, one wait cycle.
        do_reset();
        instr_re = 1; instr_addr = 32'h100; instr_sel = 4'hF;
        tick();
        #1;
        chk("i_mem_re_c1", mem_re, 1);
        chk("i_mem_addr", mem_addr, 32'h100);
        chk_acks("i_acks_c1", 3'b000);
        tick();
        mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        #1;
        chk_acks("i_acks_c2", 3'b100);
        chk("i_data", instr_data, 32'hDEADBEEF);
        tick();
        instr_re = 0; mem_ack = 0;
        #1;
        chk("i_idle_re", mem_re, 0);
        chk_acks("i_idle_acks", 3'b000);

        // Simultaneous requests from reset: DW, then I, then DR.
        do_reset();
        instr_re = 1; instr_addr = 32'h1000; instr_sel = 4'h1;
        dr_re    = 1; dr_addr    = 32'h2000; dr_sel    = 4'h3;
        dw_we    = 1; dw_addr    = 32'h3000; dw_sel    = 4'hC; dw_data = 32'hCAFE0001;
        exp_addr[0] = 32'h3000; exp_ack[0] = 3'b001;
        exp_addr[1] = 32'h1000; exp_ack[1] = 3'b100;
        exp_addr[2] = 32'h2000; exp_ack[2] = 3'b010;
        for (int g = 0; g < 3; g++) begin
            tick();
            #1;
            chk($sformatf("sim_addr%0d", g), mem_addr, exp_addr[g]);
            chk($sformatf("sim_we%0d", g), mem_we, exp_ack[g][0]);
            chk($sformatf("sim_re%0d", g), mem_re, exp_ack[g][2] | exp_ack[g][1]);
            if (exp_ack[g][0]) chk("sim_wdata", mem_wdata, 32'hCAFE0001);
            mem_ack = 1;
            #1;
            chk_acks($sformatf("sim_acks%0d", g), exp_ack[g]);
            tick();
            mem_ack = 0;
            if (exp_ack[g][2]) instr_re = 0;
            if (exp_ack[g][1]) dr_re = 0;
            if (exp_ack[g][0]) dw_we = 0;
            #1;
            chk($sformatf("sim_gap%0d", g), {mem_re, mem_we}, 2'b00);
        end

        // Fairness: DR and I held continuously with zero-wait memory.
        do_reset();
        instr_re = 1; instr_addr = 32'hA000; instr_sel = 4'hF;
        dr_re    = 1; dr_addr    = 32'hB000; dr_sel    = 4'hF;
        mem_ack  = 1;
        for (int g = 0; g < 4; g++) begin
            tick();
            #1;
            chk($sformatf("fair_addr%0d", g), mem_addr, (g % 2 == 0) ? 32'hB000 : 32'hA000);
            chk_acks($sformatf("fair_acks%0d", g), (g % 2 == 0) ? 3'b010 : 3'b100);
            tick();
            #1;
            chk_acks($sformatf("fair_idle%0d", g), 3'b000);
        end

        // Zero-wait write.
        do_reset();
        mem_ack = 1;
        dw_we = 1; dw_addr = 32'h20; dw_data = 32'h55AA; dw_sel = 4'hF;
        tick();
        #1;
        chk("zw_we", mem_we, 1);
        chk_acks("zw_acks", 3'b001);
        chk("zw_wdata", mem_wdata, 32'h55AA);
        chk("zw_addr", mem_addr, 32'h20);
        chk("zw_sel", mem_sel, 4'hF);
        tick();
        dw_we = 0;
        #1;
        chk("zw_idle", {mem_re, mem_we}, 2'b00);
        chk_acks("zw_idle_acks", 3'b000);

        // Reset mid-grant abandons the read; later mem_ack is ignored.
        do_reset();
        dr_re = 1; dr_addr = 32'h40; dr_sel = 4'h2;
        tick();
        #1;
        chk("rg_re", mem_re, 1);
        reset = 1;
        tick();
        reset = 0; dr_re = 0; mem_ack = 1;
        #1;
        chk("rg_outs", {mem_re, mem_we}, 2'b00);
        chk("rg_addr", mem_addr, 0);
        chk("rg_sel", mem_sel, 0);
        chk("rg_wdata", mem_wdata, 0);
        chk_acks("rg_acks", 3'b000);
        // Stray mem_ack in IDLE with no requests.
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            chk("stray_outs", {mem_re, mem_we}, 2'b00);
            chk_acks("stray_acks", 3'b000);
        end

        // Random traffic against the model.
        do_reset();
        owner = -1;
        data_since_i = 0;
        m_addr = '0; m_sel = '0; m_wdata = '0;
        for (int k = 0; k < 3; k++) begin on[k] = 0; seen[k] = 0; end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < 3; k++) begin
                if (seen[k]) on[k] = 0;
                seen[k] = 0;
                if (!on[k] && $urandom_range(0, 2) == 0) begin
                    on[k] = 1;
                    ra[k] = $urandom;
                    rd[k] = $urandom;
                    rs[k] = SW'($urandom);
                end
            end
            instr_re = on[0]; instr_addr = ra[0]; instr_sel = rs[0];
            dr_re    = on[1]; dr_addr    = ra[1]; dr_sel    = rs[1];
            dw_we    = on[2]; dw_addr    = ra[2]; dw_sel    = rs[2]; dw_data = rd[2];
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            #1;
            chk("rnd_re", mem_re, owner == 0 || owner == 1);
            chk("rnd_we", mem_we, owner == 2);
            chk_acks("rnd_acks", {owner == 0 && mem_ack, owner == 1 && mem_ack, owner == 2 && mem_ack});
            if (owner >= 0) begin
                chk("rnd_addr", mem_addr, m_addr);
                chk("rnd_sel", mem_sel, m_sel);
            end
            if (owner == 2) chk("rnd_wdata", mem_wdata, m_wdata);
            if (owner == 0 && mem_ack) chk("rnd_idata", instr_data, mem_rdata[31:0]);
            if (owner == 1 && mem_ack) chk("rnd_drdata", dr_data, mem_rdata);

            if (owner >= 0) begin
                if (mem_ack) begin
                    seen[owner] = 1;
                    owner = -1;
                end
            end else begin
                // I gets the port if any data access happened since its last grant.
                if (on[0] && data_since_i > 0) owner = 0;
                else if (on[2])                owner = 2;
                else if (on[1])                owner = 1;
                else if (on[0])                owner = 0;
                if (owner >= 0) begin
                    m_addr = ra[owner];
                    m_sel  = rs[owner];
                    if (owner == 2) m_wdata = rd[owner];
                    data_since_i = (owner == 0) ? 0 : data_since_i + 1;
                end
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
